// File: rtl/icape2_packet_decoder.sv
// ICAPE2 write-stream receiver: sync hunt, Type 1/Type 2 header parsing, register-write strobes.
// Optional IDCODE check enabled by defining ICAPE2_IDCODE_CHECK_EN.
module icape2_packet_decoder #(
    parameter int unsigned BIT_SWAP  = 1,
    parameter logic [31:0] DEVICE_ID = 32'h04244093
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        CSIB,
    input  logic        RDWRB,
    input  logic [31:0] I,
    output logic        SYNCED,
    output logic        REG_WE,
    output logic [4:0]  REG_ADDR,
    output logic [31:0] REG_DATA,
    output logic        RD_REQ,
    output logic [26:0] RD_CNT,
    output logic        HDR_ERR,
    output logic        ID_ERR
);

    localparam logic [31:0] SYNC_WORD   = 32'hAA995566;
    localparam logic [31:0] NOOP_WORD   = 32'h20000000;
    localparam logic [31:0] DESYNC_WORD = 32'h0000000D;
    localparam logic [4:0]  ADDR_CMD    = 5'h04;

    typedef enum logic [1:0] {ST_UNSYNC, ST_HDR, ST_DATA} state_t;

    state_t      state_q, state_d;
    logic [26:0] cnt_q, cnt_d;
    logic [4:0]  addr_q, addr_d;
    logic        t1_q, t1_d;
    logic        synced_d, we_d, rd_d, herr_d;
    logic [4:0]  reg_addr_d;
    logic [31:0] reg_data_d;
    logic [26:0] rd_cnt_d;
    logic        id_err_d, id_blk_q, id_blk_d;

    logic [31:0] w;
    logic        accept;
    logic        hdr_ok;
    logic [4:0]  hdr_addr;
    logic [26:0] hdr_cnt;

    function automatic logic [31:0] swap_bits(input logic [31:0] d);
        logic [31:0] r;
        for (int unsigned b = 0; b < 4; b++) begin
            for (int unsigned k = 0; k < 8; k++) begin
                r[8*b+k] = d[8*b+7-k];
            end
        end
        return r;
    endfunction

    assign w      = (BIT_SWAP != 0) ? swap_bits(I) : I;
    assign accept = !CSIB && !RDWRB;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        t1_d       = t1_q;
        synced_d   = SYNCED;
        we_d       = 1'b0;
        rd_d       = 1'b0;
        herr_d     = 1'b0;
        reg_addr_d = REG_ADDR;
        reg_data_d = REG_DATA;
        rd_cnt_d   = RD_CNT;
        id_err_d   = ID_ERR;
        id_blk_d   = id_blk_q;
        hdr_ok     = 1'b0;
        hdr_addr   = addr_q;
        hdr_cnt    = '0;

        if (accept) begin
            unique case (state_q)
                ST_UNSYNC: begin
                    if (w == SYNC_WORD) begin
                        state_d  = ST_HDR;
                        synced_d = 1'b1;
                    end
                end
                ST_HDR: begin
                    if (w != NOOP_WORD) begin
                        if (w[31:29] == 3'b001) begin
                            addr_d   = w[17:13];
                            t1_d     = 1'b1;
                            hdr_addr = w[17:13];
                            hdr_cnt  = {16'd0, w[10:0]};
                            hdr_ok   = 1'b1;
                        end else if (w[31:29] == 3'b010 && t1_q) begin
                            hdr_cnt = w[26:0];
                            hdr_ok  = 1'b1;
                        end else begin
                            herr_d = 1'b1;
                        end
                        if (hdr_ok) begin
                            if (w[28:27] == 2'b10 && hdr_cnt != '0) begin
                                state_d = ST_DATA;
                                cnt_d   = hdr_cnt;
                            end else if (w[28:27] == 2'b01) begin
                                rd_d       = 1'b1;
                                reg_addr_d = hdr_addr;
                                rd_cnt_d   = hdr_cnt;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    // A blocked write still consumes its payload slot.
                    if (!id_blk_q) begin
                        we_d       = 1'b1;
                        reg_addr_d = addr_q;
                        reg_data_d = w;
                    end
`ifdef ICAPE2_IDCODE_CHECK_EN
                    if (addr_q == 5'h0C && w != DEVICE_ID) begin
                        id_err_d = 1'b1;
                        id_blk_d = 1'b1;
                    end
`endif
                    cnt_d = cnt_q - 27'd1;
                    if (cnt_q == 27'd1) state_d = ST_HDR;
                    if (addr_q == ADDR_CMD && w == DESYNC_WORD) begin
                        state_d  = ST_UNSYNC;
                        synced_d = 1'b0;
                        t1_d     = 1'b0;
                        cnt_d    = '0;
                        id_blk_d = 1'b0;
                    end
                end
                default: state_d = ST_UNSYNC;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q  <= ST_UNSYNC;
            cnt_q    <= '0;
            addr_q   <= '0;
            t1_q     <= 1'b0;
            SYNCED   <= 1'b0;
            REG_WE   <= 1'b0;
            REG_ADDR <= '0;
            REG_DATA <= '0;
            RD_REQ   <= 1'b0;
            RD_CNT   <= '0;
            HDR_ERR  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            t1_q     <= t1_d;
            SYNCED   <= synced_d;
            REG_WE   <= we_d;
            REG_ADDR <= reg_addr_d;
            REG_DATA <= reg_data_d;
            RD_REQ   <= rd_d;
            RD_CNT   <= rd_cnt_d;
            HDR_ERR  <= herr_d;
        end
    end

`ifdef ICAPE2_IDCODE_CHECK_EN
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            ID_ERR   <= 1'b0;
            id_blk_q <= 1'b0;
        end else begin
            ID_ERR   <= id_err_d;
            id_blk_q <= id_blk_d;
        end
    end
`else
    assign ID_ERR   = 1'b0;
    assign id_blk_q = 1'b0;
`endif

endmodule

// File: tb/tb_icape2_packet_decoder.sv
// Directed bench for icape2_packet_decoder with a word-level reference model.
module tb_icape2_packet_decoder;

    localparam logic [31:0] SYNC = 32'hAA995566;
    localparam logic [31:0] DEV  = 32'h04244093;

    logic        CLK = 1'b0;
    logic        RSTB, CSIB, RDWRB;
    logic [31:0] I;
    logic        SYNCED, REG_WE, RD_REQ, HDR_ERR, ID_ERR;
    logic [4:0]  REG_ADDR;
    logic [31:0] REG_DATA;
    logic [26:0] RD_CNT;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_on = 1'b0;

    // model state and expected outputs
    bit          m_sync, m_t1, m_blk;
    logic [4:0]  m_addr;
    int unsigned m_left;
    logic        exp_synced, exp_we, exp_rd, exp_herr, exp_iderr;
    logic [4:0]  exp_raddr;
    logic [31:0] exp_rdata;
    logic [26:0] exp_rdcnt;

    always #5 CLK = ~CLK;

    icape2_packet_decoder #(.BIT_SWAP(1), .DEVICE_ID(DEV)) dut (
        .CLK(CLK), .RSTB(RSTB), .CSIB(CSIB), .RDWRB(RDWRB), .I(I),
        .SYNCED(SYNCED), .REG_WE(REG_WE), .REG_ADDR(REG_ADDR), .REG_DATA(REG_DATA),
        .RD_REQ(RD_REQ), .RD_CNT(RD_CNT), .HDR_ERR(HDR_ERR), .ID_ERR(ID_ERR)
    );

    function automatic logic [31:0] tb_swap(input logic [31:0] d);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = d[(k & ~7) + 7 - (k & 7)];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sync = 0; m_t1 = 0; m_blk = 0; m_addr = '0; m_left = 0;
        exp_synced = 0; exp_we = 0; exp_rd = 0; exp_herr = 0; exp_iderr = 0;
        exp_raddr = '0; exp_rdata = '0; exp_rdcnt = '0;
    endtask

    // Outputs expected after one clock edge on which word w is (or is not) accepted.
    task automatic model_step(input bit acc, input logic [31:0] w);
        int unsigned kind, op, cnt;
        bit ok;
        exp_we = 0; exp_rd = 0; exp_herr = 0;
        if (!acc) return;
        if (!m_sync) begin
            if (w == SYNC) m_sync = 1;
        end else if (m_left != 0) begin
            if (!m_blk) begin
                exp_we = 1; exp_raddr = m_addr; exp_rdata = w;
            end
`ifdef ICAPE2_IDCODE_CHECK_EN
            if (m_addr == 5'd12 && w != DEV) begin
                exp_iderr = 1; m_blk = 1;
            end
`endif
            m_left--;
            if (m_addr == 5'd4 && w == 32'd13) begin
                m_sync = 0; m_t1 = 0; m_left = 0; m_blk = 0;
            end
        end else if (w != 32'h20000000) begin
            kind = w[31:29]; op = w[28:27]; ok = 0; cnt = 0;
            if (kind == 1) begin
                m_addr = w[17:13]; m_t1 = 1; cnt = w[10:0]; ok = 1;
            end else if (kind == 2 && m_t1) begin
                cnt = w[26:0]; ok = 1;
            end else begin
                exp_herr = 1;
            end
            if (ok && op == 2) m_left = cnt;
            if (ok && op == 1) begin
                exp_rd = 1; exp_raddr = m_addr; exp_rdcnt = cnt[26:0];
            end
        end
        exp_synced = m_sync;
    endtask

    always @(negedge CLK) begin
        if (cmp_on) begin
            chk("synced",   {31'd0, SYNCED},  {31'd0, exp_synced});
            chk("reg_we",   {31'd0, REG_WE},  {31'd0, exp_we});
            chk("reg_addr", {27'd0, REG_ADDR}, {27'd0, exp_raddr});
            chk("reg_data", REG_DATA, exp_rdata);
            chk("rd_req",   {31'd0, RD_REQ},  {31'd0, exp_rd});
            chk("rd_cnt",   {5'd0, RD_CNT},   {5'd0, exp_rdcnt});
            chk("hdr_err",  {31'd0, HDR_ERR}, {31'd0, exp_herr});
            chk("id_err",   {31'd0, ID_ERR},  {31'd0, exp_iderr});
        end
    end

    task automatic send(input logic [31:0] w, input bit cs_n = 1'b0, input bit rw = 1'b0);
        @(negedge CLK); #1;
        I = tb_swap(w); CSIB = cs_n; RDWRB = rw;
        model_step(!cs_n && !rw, w);
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        @(negedge CLK); #1;
        RSTB = 1'b0; CSIB = 1'b1; RDWRB = 1'b0;
        model_reset();
        #1 chk("lit_async_reset_synced", {31'd0, SYNCED}, 32'd0);
        @(negedge CLK); #1;
        RSTB = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        RSTB = 1'b0; CSIB = 1'b1; RDWRB = 1'b0; I = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        cmp_on = 1'b1;
        do_reset();
        chk("lit_reset_we", {31'd0, REG_WE}, 32'd0);

        // sync hunt
        send(32'hFFFFFFFF); send(32'hFFFFFFFF);
        chk("lit_presync_synced", {31'd0, SYNCED}, 32'd0);
        send(SYNC);
        chk("lit_sync", {31'd0, SYNCED}, 32'd1);

        // single Type 1 write to CMD
        send(32'h30008001); send(32'h00000007);
        chk("lit_t1_we", {31'd0, REG_WE}, 32'd1);
        chk("lit_t1_addr", {27'd0, REG_ADDR}, 32'h4);
        chk("lit_t1_data", REG_DATA, 32'h7);

        // cnt-0 Type 1 then Type 2 with paused payload
        send(32'h30002000); send(32'h50000003);
        send(32'hA1A1A1A1);
        send(32'h0, 1'b1); send(32'h0, 1'b1);
        chk("lit_pause_we", {31'd0, REG_WE}, 32'd0);
        send(32'hDEADBEEF, 1'b0, 1'b1);
        send(32'hA2A2A2A2); send(32'hA3A3A3A3);
        chk("lit_t2_addr", {27'd0, REG_ADDR}, 32'h1);
        chk("lit_t2_data", REG_DATA, 32'hA3A3A3A3);
        send(32'h20000000);
        send(32'h48000005);
        chk("lit_t2_rd", {31'd0, RD_REQ}, 32'd1);
        chk("lit_t2_rdcnt", {5'd0, RD_CNT}, 32'd5);

        // header errors
        do_reset();
        send(SYNC); send(32'h50000002);
        chk("lit_herr_t2", {31'd0, HDR_ERR}, 32'd1);
        chk("lit_herr_synced", {31'd0, SYNCED}, 32'd1);
        send(32'hE0000000);
        chk("lit_herr_e0", {31'd0, HDR_ERR}, 32'd1);
        send(32'h20000000);
        chk("lit_noop_noerr", {31'd0, HDR_ERR}, 32'd0);

        // read header, then DESYNC
        send(32'h2800E001);
        chk("lit_rd", {31'd0, RD_REQ}, 32'd1);
        chk("lit_rd_addr", {27'd0, REG_ADDR}, 32'h7);
        chk("lit_rd_cnt", {5'd0, RD_CNT}, 32'd1);
        send(32'h30008001); send(32'h0000000D);
        chk("lit_desync_we", {31'd0, REG_WE}, 32'd1);
        chk("lit_desync_synced", {31'd0, SYNCED}, 32'd0);
        send(32'h30008001); send(32'h00000007);
        chk("lit_post_desync_we", {31'd0, REG_WE}, 32'd0);

        // sync word as payload is just data
        send(SYNC); send(32'h30004002); send(SYNC);
        chk("lit_payload_sync", REG_DATA, SYNC);
        send(32'h12345678);
        chk("lit_payload_2", REG_DATA, 32'h12345678);

        // maximum Type 2 count, interrupted by reset
        send(32'h30006000); send(32'h57FFFFFF);
        for (int n = 0; n < 5; n++) send(32'h100 + n);
        chk("lit_max_addr", {27'd0, REG_ADDR}, 32'h3);
        do_reset();
        send(32'h30008001); send(32'h00000007);
        chk("lit_after_reset_we", {31'd0, REG_WE}, 32'd0);

`ifdef ICAPE2_IDCODE_CHECK_EN
        send(SYNC); send(32'h30018001); send(32'h12345678);
        chk("lit_iderr", {31'd0, ID_ERR}, 32'd1);
        send(32'h30008001); send(32'h00000005);
        chk("lit_id_block", {31'd0, REG_WE}, 32'd0);
        do_reset();
        send(SYNC); send(32'h30018001); send(DEV);
        chk("lit_id_ok", {31'd0, ID_ERR}, 32'd0);
        chk("lit_id_ok_we", {31'd0, REG_WE}, 32'd1);
`endif

        send(32'h0, 1'b1); send(32'h0, 1'b1);
        @(negedge CLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
